// File: rtl/sub_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
// State encoding plus the counter-width function.
package sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/full_sub.sv
// One-bit full subtractor: d = a - b - c, bo = borrow out.
// Shared bit-time datapath cell.
module full_sub (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic d,
  output logic bo
);

  assign d  = a ^ b ^ c;
  assign bo = (~a & b) | (~(a ^ b) & c);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial subtractor: LSB-first, one bit per cycle
// through a single full_sub cell.
module serial_sub
  import sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             bin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int unsigned LW = clog2(WIDTH);
  localparam int unsigned CW = (LW > 0) ? LW : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q, diff_q, diff_d;
  logic [CW-1:0]    cnt_q;
  logic             brw_q, bout_q;
  logic             ready_q, busy_q, done_q;
  logic             d_w, bo_w;

  full_sub u_cell (
    .a  (a_q[0]),
    .b  (b_q[0]),
    .c  (brw_q),
    .d  (d_w),
    .bo (bo_w)
  );

  // New bit enters at the MSB so the LSB-first result lands aligned.
  if (WIDTH > 1) begin : g_wide
    assign diff_d = {d_w, diff_q[WIDTH-1:1]};
  end else begin : g_one
    assign diff_d = d_w;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      cnt_q   <= '0;
      brw_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= a_in;
            b_q     <= b_in;
            brw_q   <= bin;
            cnt_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            state_q <= SHIFT;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        SHIFT: begin
          diff_q <= diff_d;
          brw_q  <= bo_w;
          a_q    <= a_q >> 1;
          b_q    <= b_q >> 1;
          cnt_q  <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            bout_q  <= bo_w;
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ready = ready_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign diff  = diff_q;
  assign bout  = bout_q;

endmodule

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub (WIDTH=8): directed
// cases plus randomized operands against an arithmetic model.
module tb_serial_sub;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a_in, b_in;
  logic         bin;
  logic         ready, busy, done, bout;
  logic [W-1:0] diff;

  int n_chk  = 0;
  int n_pass = 0;

  serial_sub #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a_in  (a_in),
    .b_in  (b_in),
    .bin   (bin),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // {borrow, difference} from plain integer arithmetic
  function automatic logic [W:0] ref_sub(input logic [W-1:0] a,
                                         input logic [W-1:0] b,
                                         input logic bi);
    int r;
    r = int'(a) - int'(b) - int'(bi);
    return {r < 0, W'(r)};
  endfunction

  task automatic rand_in();
    a_in = W'($urandom);
    b_in = W'($urandom);
    bin  = 1'($urandom);
  endtask

  // Called at a negedge in IDLE; returns at a negedge in IDLE.
  task automatic do_op(input string tag,
                       input logic [W-1:0] a,
                       input logic [W-1:0] b,
                       input logic bi,
                       input bit spam);
    logic [W:0] e;
    int lat;
    bit seq_ok;
    e = ref_sub(a, b, bi);
    lat = 0;
    seq_ok = 1;
    chk({tag, ":ready_pre"}, ready, 1);
    start = 1'b1;
    a_in = a;
    b_in = b;
    bin = bi;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        lat = k;
        break;
      end
      if (busy !== 1'b1 || ready !== 1'b0) seq_ok = 0;
      start = spam && (k == 3);
      if (spam && k == 3) begin
        a_in = 8'hFF;
        b_in = 8'h00;
        bin = 1'b0;
      end else begin
        rand_in();
      end
    end
    start = 1'b0;
    rand_in();
    chk({tag, ":latency"}, lat, W + 1);
    chk({tag, ":shift_flags"}, seq_ok, 1);
    chk({tag, ":diff"}, diff, e[W-1:0]);
    chk({tag, ":bout"}, bout, e[W]);
    @(negedge clk);
    chk({tag, ":done_pulse"}, {done, ready}, 2'b01);
    chk({tag, ":diff_hold"}, diff, e[W-1:0]);
  endtask

  task automatic no_done(input string tag, input int n);
    bit seen;
    seen = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1;
    end
    chk(tag, seen, 0);
  endtask

  initial begin
    logic [W:0] q[$];
    logic [W:0] e;
    bit b2b_ok;

    rst = 1'b1;
    start = 1'b0;
    a_in = '0;
    b_in = '0;
    bin = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset", {ready, busy, done, bout, diff}, {4'b1000, 8'h00});
    rst = 1'b0;
    @(negedge clk);

    do_op("basic", 8'h5A, 8'h23, 1'b0, 0);
    do_op("underflow", 8'h00, 8'h01, 1'b0, 0);
    do_op("bin_a", 8'h10, 8'h10, 1'b1, 0);
    do_op("bin_b", 8'h80, 8'h7F, 1'b1, 0);
    do_op("ign_start", 8'h5A, 8'h23, 1'b0, 1);
    no_done("ign_no_2nd", 12);

    // abort: accept at cycle 0, rst during cycle 4
    start = 1'b1;
    a_in = 8'h5A;
    b_in = 8'h23;
    bin = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      start = 1'b0;
      rst = (k == 4);
    end
    chk("abort_state", {ready, busy, done, bout, diff}, {4'b1000, 8'h00});
    no_done("abort_no_done", 12);
    do_op("after_abort", 8'h05, 8'h07, 1'b0, 0);

    // continuous start: accepts at cycles 0, 10, 20
    b2b_ok = 1;
    for (int c = 0; c <= 30; c++) begin
      if (c > 0) @(negedge clk);
      if (c % 10 == 9) begin
        chk($sformatf("b2b_done_%0d", c), done, 1);
        e = (q.size() > 0) ? q.pop_front() : '0;
        chk($sformatf("b2b_res_%0d", c), {bout, diff}, e);
      end else if (done !== 1'b0) begin
        b2b_ok = 0;
      end
      start = (c < 30);
      rand_in();
      if (c % 10 == 0 && c < 30) q.push_back(ref_sub(a_in, b_in, bin));
    end
    chk("b2b_no_extra_done", b2b_ok, 1);
    start = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 20; i++) begin
      do_op($sformatf("rand%0d", i), W'($urandom), W'($urandom),
            1'($urandom), 1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/serial_sub.md
SERIAL_SUB -- requirements
Module: serial_sub

Interface
REQ-001 SHALL have parameter WIDTH, default 8, the operand width in bits (legal range 1..32).
REQ-002 SHALL have port clk  input  1  the single clock; every register is updated on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port start  input  1  request to begin one subtraction; sampled only while ready=1.
REQ-005 SHALL have port a_in  input  WIDTH  minuend; captured in the cycle start is accepted.
REQ-006 SHALL have port b_in  input  WIDTH  subtrahend; captured in the cycle start is accepted.
REQ-007 SHALL have port bin  input  1  initial borrow-in; captured in the cycle start is accepted.
REQ-008 SHALL have port ready  output  1  high only in IDLE (block can accept start).
REQ-009 SHALL have port busy  output  1  high only in SHIFT.
REQ-010 SHALL have port done  output  1  one-cycle pulse, high only in DONE.
REQ-011 SHALL have port diff  output  WIDTH  registered difference.
REQ-012 SHALL have port bout  output  1  registered final borrow-out.

Function
REQ-013 SHALL implement FSM states IDLE, SHIFT and DONE.
REQ-014 Transition: IDLE->SHIFT when start=1; SHIFT->DONE when the bit counter reaches WIDTH-1; DONE->IDLE unconditionally.
REQ-015 On accept, SHALL load the A and B shift registers and the borrow flop from a_in, b_in and bin, clear the counter, and clear diff and bout.
REQ-016 Each SHIFT cycle SHALL drive one full_sub cell with a=A[0], b=B[0], c=borrow flop.
REQ-017 Each SHIFT cycle SHALL shift the cell's d output into diff from the MSB end (LSB-first processing), store the cell's bo in the borrow flop, shift A and B right by one, and increment the counter.
REQ-018 Latency: with start accepted in cycle 0, SHIFT SHALL occupy cycles 1..WIDTH and done SHALL be high in cycle WIDTH+1.
REQ-019 Result: diff SHALL equal (a_in - b_in - bin) mod 2^WIDTH; bout SHALL be 1 iff a_in < b_in + bin.
REQ-020 diff and bout SHALL be valid from the done cycle and held until the next accepted start.
REQ-021 start in SHIFT or DONE SHALL be ignored and SHALL NOT corrupt the operands in flight.
REQ-022 start in the first IDLE cycle after DONE SHALL be accepted; back-to-back throughput is one result per WIDTH+2 cycles.
REQ-023 a_in, b_in and bin SHALL be don't-care in every cycle except the accept cycle.
REQ-024 For WIDTH=1, SHIFT SHALL last exactly one cycle.

Reset
REQ-025 With rst=1 at a clock edge, the block SHALL enter IDLE and set ready=1, busy=0, done=0, diff=0, bout=0, counter=0 and borrow flop=0.
REQ-026 rst SHALL take priority over start and SHALL abort an operation in progress; no done pulse SHALL follow for the aborted operation.

Structure
REQ-027 Package sub_pkg SHALL hold the state enumeration and the counter-width function clog2(WIDTH).
REQ-028 The single existing full_sub cell SHALL be instantiated once as the bit-time datapath; serial_sub SHALL implement no other borrow logic.
REQ-029 The counter SHALL be max(1, clog2(WIDTH)) bits wide.

Verification (WIDTH=8)
REQ-030 Basic: a=0x5A, b=0x23, bin=0, start at cycle 0 -> done at cycle 9, diff=0x37, bout=0.
REQ-031 Underflow: a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1.
REQ-032 Borrow-in: a=0x10, b=0x10, bin=1 -> diff=0xFF, bout=1; and a=0x80, b=0x7F, bin=1 -> diff=0x00, bout=0.
REQ-033 Ignored start: start with 0x5A/0x23, then at cycle 3 start with 0xFF/0x00 -> a single done at cycle 9 with diff=0x37, and no second done.
REQ-034 Reset mid-operation: rst=1 at cycle 4 -> cycle 5 shows ready=1, diff=0, and no done; then start 0x05/0x07 -> diff=0xFE, bout=1.
REQ-035 Back-to-back: start asserted continuously -> done at cycles 9, 19 and 29, each result correct for the operands sampled at cycles 0, 10 and 20.
